// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection between fetch and load/store requesters.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int RR_EN = 0
) (
   input  logic if_req,
   input  logic d_req,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   // Fixed mode always prefers data; round-robin only matters on a tie,
   // where the side that did not win last time goes next.
   always_comb begin
      grant_valid = if_req | d_req;
      grant_owner = d_req ? DATA : FETCH;
      if (RR_EN != 0 && if_req && d_req) begin
         grant_owner = ~last_owner;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and the load/store datapath.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RR_EN  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   state_t state, state_nxt;
   owner_t owner, last_owner;
   logic   grant_valid, grant_owner;
   logic   latch_req, take_rsp;

   mem_arb_pick #(.RR_EN(RR_EN)) u_pick (
      .if_req      (if_req),
      .d_req       (d_req),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; also produces the latch/response strobes.
   always_comb begin
      state_nxt = state;
      latch_req = 1'b0;
      take_rsp  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               latch_req = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_rvalid) begin
               take_rsp  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields and read data are registered; rvalid pulses clear
   // every cycle unless a response lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= FETCH;
         last_owner <= FETCH;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_rvalid  <= 1'b0;
         d_rvalid   <= 1'b0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if (latch_req) begin
            owner      <= owner_t'(grant_owner);
            last_owner <= owner_t'(grant_owner);
            if (grant_owner == DATA) begin
               mem_we    <= d_we;
               mem_be    <= d_be;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end else begin
               mem_we    <= 1'b0;
               mem_be    <= '1;
               mem_addr  <= if_addr;
               mem_wdata <= '0;
            end
         end
         if (take_rsp) begin
            if (owner == DATA) begin
               d_rdata  <= mem_rdata;
               d_rvalid <= 1'b1;
            end else begin
               if_rdata  <= mem_rdata;
               if_rvalid <= 1'b1;
            end
         end
      end
   end

   assign mem_req = (state == REQ);
   assign busy    = (state != IDLE);
   assign if_gnt  = mem_req & mem_gnt & (owner == FETCH);
   assign d_gnt   = mem_req & mem_gnt & (owner == DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one fixed-priority and one round-robin instance share the
// same stimulus; each step checks outputs with immediate assertions.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_be;

   logic        f_if_gnt, f_if_rvalid, f_d_gnt, f_d_rvalid, f_mem_req, f_mem_we, f_busy;
   logic [31:0] f_if_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
   logic [3:0]  f_mem_be;
   logic        r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid, r_mem_req, r_mem_we, r_busy;
   logic [31:0] r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
   logic [3:0]  r_mem_be;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_fix (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(f_if_gnt),
      .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
      .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_be(f_mem_be),
      .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(f_busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_rr (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(r_if_gnt),
      .if_rvalid(r_if_rvalid), .if_rdata(r_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
      .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_be(r_mem_be),
      .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(r_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      tick(); tick();
      settle();
      // Reset state
      chk("rst_busy",     f_busy, 0);
      chk("rst_mem_req",  f_mem_req, 0);
      chk("rst_mem_addr", f_mem_addr, 0);
      chk("rst_mem_be",   f_mem_be, 0);
      chk("rst_if_rdata", f_if_rdata, 0);
      chk("rst_d_rdata",  f_d_rdata, 0);
      chk("rst_rvalid",   {f_if_rvalid, f_d_rvalid}, 0);
      rst = 0;
      tick();

      // Lone fetch, minimum latency
      if_req = 1; if_addr = 32'h100; mem_gnt = 1;
      settle();
      chk("lf_c0_busy", f_busy, 0);
      chk("lf_c0_mreq", f_mem_req, 0);
      tick(); settle();
      chk("lf_c1_mreq", f_mem_req, 1);
      chk("lf_c1_addr", f_mem_addr, 32'h100);
      chk("lf_c1_we",   f_mem_we, 0);
      chk("lf_c1_be",   f_mem_be, 4'hF);
      chk("lf_c1_gnt",  {f_if_gnt, f_d_gnt}, 2'b10);
      chk("lf_c1_busy", f_busy, 1);
      tick();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
      settle();
      chk("lf_c2_mreq",   f_mem_req, 0);
      chk("lf_c2_busy",   f_busy, 1);
      chk("lf_c2_rvalid", f_if_rvalid, 0);
      tick();
      mem_rvalid = 0; mem_gnt = 0;
      settle();
      chk("lf_c3_rvalid", {f_if_rvalid, f_d_rvalid}, 2'b10);
      chk("lf_c3_rdata",  f_if_rdata, 32'h00500093);
      chk("lf_c3_busy",   f_busy, 0);
      tick(); settle();
      chk("lf_c4_rvalid", f_if_rvalid, 0);
      chk("lf_c4_hold",   f_if_rdata, 32'h00500093);

      // Store with stalled backend
      do_reset();
      d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
      mem_gnt = 0;
      settle();
      chk("st_c0_gnt", f_d_gnt, 0);
      for (int c = 1; c <= 3; c++) begin
         tick(); settle();
         chk("st_stall_req",  f_mem_req, 1);
         chk("st_stall_flds", {f_mem_we, f_mem_be, f_mem_addr, f_mem_wdata},
             {1'b1, 4'h3, 32'h2004, 32'hDEADBEEF});
         chk("st_stall_gnt",  {f_if_gnt, f_d_gnt}, 0);
      end
      tick();
      mem_gnt = 1;
      settle();
      chk("st_c4_flds", {f_mem_req, f_mem_we, f_mem_be, f_mem_addr, f_mem_wdata},
          {1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF});
      chk("st_c4_gnt", {f_if_gnt, f_d_gnt}, 2'b01);
      tick();
      d_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
      settle();
      chk("st_c5_mreq",   f_mem_req, 0);
      chk("st_c5_rvalid", f_d_rvalid, 0);
      tick();
      mem_rvalid = 0;
      settle();
      chk("st_c6_rvalid", {f_if_rvalid, f_d_rvalid}, 2'b01);
      tick(); settle();
      chk("st_c7_rvalid", {f_if_rvalid, f_d_rvalid}, 2'b00);

      // Simultaneous requests, fixed priority
      do_reset();
      if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
      mem_gnt = 1;
      tick(); settle();
      chk("fp_t1_addr", f_mem_addr, 32'h2000);
      chk("fp_t1_gnt",  {f_if_gnt, f_d_gnt}, 2'b01);
      tick();
      d_req = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA0001;
      tick();
      mem_rvalid = 0;
      settle();
      chk("fp_t1_rvalid", {f_if_rvalid, f_d_rvalid}, 2'b01);
      chk("fp_t1_rdata",  f_d_rdata, 32'hAAAA0001);
      chk("fp_idle",      f_busy, 0);
      tick(); settle();
      chk("fp_t2_addr", {f_mem_we, f_mem_addr}, {1'b0, 32'h100});
      chk("fp_t2_gnt",  {f_if_gnt, f_d_gnt}, 2'b10);
      tick();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'hBBBB0002;
      tick();
      mem_rvalid = 0;
      settle();
      chk("fp_t2_rvalid", {f_if_rvalid, f_d_rvalid}, 2'b10);
      chk("fp_t2_rdata",  f_if_rdata, 32'hBBBB0002);
      chk("fp_t2_dhold",  f_d_rdata, 32'hAAAA0001);

      // Simultaneous requests held for 4 transactions, both modes
      do_reset();
      if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
      for (int t = 0; t < 4; t++) begin
         tick(); settle();
         chk("rr_addr",  r_mem_addr, (t % 2 == 0) ? 32'h2000 : 32'h100);
         chk("rr_gnt",   {r_if_gnt, r_d_gnt}, (t % 2 == 0) ? 2'b01 : 2'b10);
         chk("fix_addr", f_mem_addr, 32'h2000);
         tick();
         tick(); settle();
         chk("rr_rvalid", {r_if_rvalid, r_d_rvalid}, (t % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle_inputs();

      // Reset mid-WAIT, then a late response
      do_reset();
      d_req = 1; d_addr = 32'h3000; d_be = 4'hF; mem_gnt = 1;
      tick(); settle();
      chk("rw_req", f_mem_req, 1);
      tick();
      d_req = 0; mem_gnt = 0; rst = 1;
      settle();
      chk("rw_wait_busy", f_busy, 1);
      tick();
      rst = 0; mem_rvalid = 1; mem_rdata = 32'hCAFECAFE;
      settle();
      chk("rw_idle", {f_busy, f_mem_req, f_d_rvalid}, 3'b000);
      tick();
      mem_rvalid = 0;
      settle();
      chk("rw_no_pulse", {f_busy, f_if_rvalid, f_d_rvalid}, 3'b000);
      chk("rw_rdata",    f_d_rdata, 0);

      // Spurious responses in IDLE and in REQ before grant
      do_reset();
      mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
      tick(); settle();
      chk("sp_idle_pulse", {f_if_rvalid, f_d_rvalid, f_busy}, 3'b000);
      chk("sp_idle_rdata", {f_if_rdata, f_d_rdata}, 64'h0);
      if_req = 1; if_addr = 32'h200; mem_rvalid = 0;
      tick();
      mem_rvalid = 1; mem_rdata = 32'hEEEE0000;
      tick(); settle();
      chk("sp_req_state", {f_mem_req, f_busy}, 2'b11);
      chk("sp_req_pulse", {f_if_rvalid, f_d_rvalid}, 2'b00);
      chk("sp_req_rdata", {f_if_rdata, f_d_rdata}, 64'h0);
      mem_rvalid = 0; mem_gnt = 1;
      tick();
      if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_rvalid = 0;
      settle();
      chk("sp_final_pulse", {f_if_rvalid, f_d_rvalid}, 2'b10);
      chk("sp_final_rdata", f_if_rdata, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch and the load/store datapath.
- Arbitrates one transaction at a time, sequences the memory request/grant/response handshake, and routes read data back to the owner.
- Drives a busy/stall indication so PC update and register writeback hold while an access is outstanding.
- Sits between the fetch stage, the data-memory interface (mem_read/mem_write decode) and the memory backend.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RR_EN, 0, arbitration mode: 0 = fixed data-over-fetch priority; 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word, registered
- d_req  in  1  data request; held with all d_* fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables (stores)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  DATA_W  load data, registered
- mem_req  out  1  backend request
- mem_we  out  1  backend write enable
- mem_be  out  DATA_W/8  backend byte enables
- mem_addr  out  ADDR_W  backend address
- mem_wdata  out  DATA_W  backend write data
- mem_gnt  in  1  backend accepts the request this cycle
- mem_rvalid  in  1  backend response (read data or write ack)
- mem_rdata  in  DATA_W  backend read data
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0; owner=FETCH; last_owner=FETCH.
- FSM states: IDLE, REQ, WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, any request: pick an owner and latch its address, we, be and wdata into the mem_* registers.
  - A fetch latches mem_we=0 and mem_be=all ones.
  - Next state is REQ, so mem_req rises the cycle after the request is sampled.
- Owner pick, RR_EN=0: data wins whenever d_req=1.
- Owner pick, RR_EN=1: on simultaneous requests, grant the requester that is not last_owner; a lone request always wins. last_owner updates on grant.
- REQ: mem_req=1 and all mem_* fields are held stable.
  - if_gnt = mem_gnt & (owner==FETCH); d_gnt = mem_gnt & (owner==DATA). These are combinational, in the same cycle as mem_gnt.
  - On mem_gnt, go to WAIT and deassert mem_req on the next edge.
- WAIT: mem_req=0. On mem_rvalid, register mem_rdata into the owner's rdata and pulse the owner's rvalid for exactly one cycle. Return to IDLE.
  - For stores, d_rvalid is the completion ack; d_rdata is still loaded and its value is don't-care.
- Minimum transaction: request sampled at cycle 0, mem_req at cycle 1, gnt at cycle 1, rvalid at cycle 2, requester rvalid at cycle 3.
- IDLE is always visited between transactions. There is one outstanding transaction maximum.
- busy=1 in REQ and WAIT, combinational from state.
- Boundary: mem_rvalid in IDLE or REQ is ignored and produces no pulse.
- Boundary: mem_gnt outside REQ is ignored.
- Boundary: a requester dropping its req before gnt is a protocol violation. The latched request completes anyway.
- Boundary: the non-owner's req is left pending; it is arbitrated in the next IDLE.
- Boundary: rst in REQ or WAIT forces IDLE next edge, mem_req=0 and no rvalid pulse. A late mem_rvalid after reset is ignored as IDLE.
- if_rdata and d_rdata hold their last value until the next response for that port.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2
  - owner encoding: FETCH=1'b0, DATA=1'b1
- One natural combinational sub-module, mem_arb_pick:
  - inputs: if_req, d_req, last_owner, RR_EN
  - outputs: grant_valid, grant_owner
- The FSM and datapath registers stay in the top module.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100, mem_gnt=1, mem_rvalid at cycle 2 with rdata=0x00500093 -> mem_req high at cycle 1 only, mem_we=0, mem_be=4'hF, if_gnt at cycle 1, if_rvalid=1 and if_rdata=0x00500093 at cycle 3, busy high cycles 1-2.
- Store with stalled backend: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'h3, mem_gnt low for 3 cycles -> mem_req and all fields stable cycles 1-4, d_gnt only at cycle 4, single d_rvalid pulse after mem_rvalid, if_rvalid stays 0.
- Simultaneous requests with RR_EN=0: if_req=d_req=1 -> data served first (addr 0x2000), fetch (0x100) served in the following IDLE.
- Simultaneous requests with RR_EN=1: both held for 4 transactions -> owners alternate DATA, FETCH, DATA, FETCH.
- Reset mid-WAIT: assert rst in WAIT, then mem_rvalid=1 the next cycle -> state IDLE, mem_req=0, no rvalid pulse, busy=0.
- Spurious responses: mem_rvalid=1 while in IDLE, and while in REQ before mem_gnt -> no if_rvalid/d_rvalid pulse, if_rdata and d_rdata unchanged.
